// File: rtl/draw_arbiter_pkg.sv
// Shared game definitions: FSM state codes, screen geometry, colours and
// draw-request owner codes used by the arbiter and its bench.
package game_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAW  = 2'd1,
        S_CLEAR = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_P1  = 2'd0,
        OWN_P2  = 2'd1,
        OWN_CLR = 2'd2
    } owner_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_P1    = 3'b100;
    localparam logic [2:0] COL_P2    = 3'b001;

endpackage

// File: rtl/draw_arbiter_if.sv
// Requester and VGA-port signals of the draw arbiter bundled as one interface;
// the arbiter takes the slave side, the players/controller/VGA side the master.
interface draw_arbiter_if;

    // Handshake: a requester raises req (or clear_req) with x/y/col stable and
    // holds them until it sees its one-cycle done; it drops req on that same
    // cycle. Coordinates are latched at grant, so later changes are ignored.
    logic       clear_req;
    logic       clear_done;
    logic       req1;
    logic [7:0] x1;
    logic [6:0] y1;
    logic [2:0] col1;
    logic       done1;
    logic       req2;
    logic [7:0] x2;
    logic [6:0] y2;
    logic [2:0] col2;
    logic       done2;
    logic       busy;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport slave (
        input  clear_req, req1, x1, y1, col1, req2, x2, y2, col2,
        output clear_done, done1, done2, busy,
        output vga_x, vga_y, vga_colour, vga_plot
    );

    modport master (
        output clear_req, req1, x1, y1, col1, req2, x2, y2, col2,
        input  clear_done, done1, done2, busy,
        input  vga_x, vga_y, vga_colour, vga_plot
    );

endinterface

// File: rtl/draw_arbiter_rect_scanner.sv
// Row-major pixel counter over either a BOX_W x BOX_H box or the whole screen,
// selected by mode; last flags the final pixel of the current sweep.
module rect_scanner #(
    parameter int BOX_W = 4,
    parameter int BOX_H = 4,
    parameter int SCR_W = 160,
    parameter int SCR_H = 120
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       step,
    input  logic       mode,
    output logic [7:0] cx,
    output logic [6:0] cy,
    output logic       last
);

    localparam logic [7:0] BOX_X_MAX = 8'(BOX_W - 1);
    localparam logic [6:0] BOX_Y_MAX = 7'(BOX_H - 1);
    localparam logic [7:0] SCR_X_MAX = 8'(SCR_W - 1);
    localparam logic [6:0] SCR_Y_MAX = 7'(SCR_H - 1);

    logic [7:0] x_max;
    logic [6:0] y_max;

    always_comb begin
        x_max = mode ? SCR_X_MAX : BOX_X_MAX;
        y_max = mode ? SCR_Y_MAX : BOX_Y_MAX;
        last  = (cx == x_max) && (cy == y_max);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cx <= '0;
            cy <= '0;
        end else if (start) begin
            cx <= '0;
            cy <= '0;
        end else if (step) begin
            if (cx == x_max) begin
                cx <= '0;
                cy <= (cy == y_max) ? '0 : cy + 7'd1;
            end else begin
                cx <= cx + 8'd1;
            end
        end
    end

endmodule

// File: rtl/draw_arbiter.sv
// Arbitrates the single VGA pixel port between two player box requests and a
// full-screen clear, sweeping the granted rectangle one pixel per cycle.
module draw_arbiter
    import game_pkg::*;
#(
    parameter int         BOX_W        = 4,
    parameter int         BOX_H        = 4,
    parameter logic [2:0] CLEAR_COLOUR = COL_BLACK
) (
    input  logic            clk,
    input  logic            resetn,
    draw_arbiter_if.slave   bus,
    output state_t          dbg_state
);

    state_t     state_q, state_d;
    owner_t     owner_q, last_grant_q, grant_owner;
    logic       grant;
    logic [7:0] bx_q;
    logic [6:0] by_q;
    logic [2:0] col_q;
    logic [7:0] cx;
    logic [6:0] cy;
    logic       scan_last, scan_start, scan_step, scan_mode;
    logic [8:0] sum_x;
    logic [7:0] sum_y;

    assign scan_start = (state_q == S_IDLE);
    assign scan_step  = (state_q == S_DRAW) || (state_q == S_CLEAR);
    assign scan_mode  = (owner_q == OWN_CLR);

    rect_scanner #(
        .BOX_W (BOX_W),
        .BOX_H (BOX_H),
        .SCR_W (SCREEN_W),
        .SCR_H (SCREEN_H)
    ) u_scan (
        .clk    (clk),
        .resetn (resetn),
        .start  (scan_start),
        .step   (scan_step),
        .mode   (scan_mode),
        .cx     (cx),
        .cy     (cy),
        .last   (scan_last)
    );

    // Clear wins outright; a player tie goes to whoever was not served last.
    always_comb begin
        grant       = 1'b0;
        grant_owner = OWN_P1;
        if (state_q == S_IDLE) begin
            if (bus.clear_req) begin
                grant       = 1'b1;
                grant_owner = OWN_CLR;
            end else if (bus.req1 && bus.req2) begin
                grant       = 1'b1;
                grant_owner = (last_grant_q == OWN_P2) ? OWN_P1 : OWN_P2;
            end else if (bus.req1) begin
                grant       = 1'b1;
                grant_owner = OWN_P1;
            end else if (bus.req2) begin
                grant       = 1'b1;
                grant_owner = OWN_P2;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant) state_d = (grant_owner == OWN_CLR) ? S_CLEAR : S_DRAW;
            S_DRAW:  if (scan_last) state_d = S_DONE;
            S_CLEAR: if (scan_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_P1;
            last_grant_q <= OWN_P2;
            bx_q         <= '0;
            by_q         <= '0;
            col_q        <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q <= grant_owner;
                case (grant_owner)
                    OWN_P1: begin
                        bx_q         <= bus.x1;
                        by_q         <= bus.y1;
                        col_q        <= bus.col1;
                        last_grant_q <= OWN_P1;
                    end
                    OWN_P2: begin
                        bx_q         <= bus.x2;
                        by_q         <= bus.y2;
                        col_q        <= bus.col2;
                        last_grant_q <= OWN_P2;
                    end
                    default: begin
                        bx_q  <= '0;
                        by_q  <= '0;
                        col_q <= CLEAR_COLOUR;
                    end
                endcase
            end
        end
    end

    // Wide sums so off-screen pixels are recognised instead of wrapping on-screen.
    assign sum_x = {1'b0, bx_q} + {1'b0, cx};
    assign sum_y = {1'b0, by_q} + {1'b0, cy};

    always_comb begin
        bus.vga_x      = '0;
        bus.vga_y      = '0;
        bus.vga_colour = '0;
        bus.vga_plot   = 1'b0;
        bus.done1      = 1'b0;
        bus.done2      = 1'b0;
        bus.clear_done = 1'b0;
        bus.busy       = (state_q != S_IDLE);
        dbg_state      = state_q;
        case (state_q)
            S_DRAW, S_CLEAR: begin
                bus.vga_x      = sum_x[7:0];
                bus.vga_y      = sum_y[6:0];
                bus.vga_colour = col_q;
                bus.vga_plot   = (state_q == S_CLEAR) ||
                                 ((sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H)));
            end
            S_DONE: begin
                bus.done1      = (owner_q == OWN_P1);
                bus.done2      = (owner_q == OWN_P2);
                bus.clear_done = (owner_q == OWN_CLR);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_draw_arbiter.sv
// Bench for draw_arbiter: per-cycle job-level reference model plus a table of
// single-box cases and hand-written reset, round-robin and clear sequences.
module tb_draw_arbiter;
    import game_pkg::*;

    localparam int BW = 4;
    localparam int BH = 4;

    typedef struct {
        int         player;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] col;
        int         plots;
        int         cyc;
        logic [2:0] who;
        logic [7:0] lx;
        logic [6:0] ly;
    } vec_t;

    logic   clk = 1'b0;
    logic   resetn;
    state_t dbg_state;
    int     checks = 0;
    int     failures = 0;

    draw_arbiter_if bus ();

    draw_arbiter #(.BOX_W(BW), .BOX_H(BH), .CLEAR_COLOUR(3'b000)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: queue of expected per-cycle outputs
    // record = {busy, plot, x[8], y[7], col[3], done1, done2, clear_done, is_pixel}
    logic [23:0] exp_q[$];
    int          m_last = 2;
    logic [23:0] chk_e, chk_a;
    logic        chk_idle;

    function automatic logic [23:0] mk(input logic busy, input logic plot, input logic [7:0] x,
                                       input logic [6:0] y, input logic [2:0] col, input logic d1,
                                       input logic d2, input logic dc, input logic pix);
        return {busy, plot, x, y, col, d1, d2, dc, pix};
    endfunction

    task automatic push_box(input int bx, input int by, input logic [2:0] col, input logic [2:0] who);
        for (int dy = 0; dy < BH; dy++)
            for (int dx = 0; dx < BW; dx++) begin
                int px = bx + dx;
                int py = by + dy;
                exp_q.push_back(mk(1'b1, (px < 160) && (py < 120), 8'(px), 7'(py), col,
                                   1'b0, 1'b0, 1'b0, 1'b1));
            end
        exp_q.push_back(mk(1'b1, 1'b0, 8'd0, 7'd0, 3'd0, who[0], who[1], who[2], 1'b0));
    endtask

    always @(negedge clk) begin
        chk_idle = 1'b0;
        if (!resetn) begin
            exp_q.delete();
            m_last = 2;
            chk_e  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        end else if (exp_q.size() == 0) begin
            chk_e    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
            chk_idle = 1'b1;
        end else begin
            chk_e = exp_q.pop_front();
        end
        if (chk_e[0])
            chk_a = mk(bus.busy, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour,
                       bus.done1, bus.done2, bus.clear_done, 1'b1);
        else
            chk_a = mk(bus.busy, bus.vga_plot, 8'd0, 7'd0, 3'd0,
                       bus.done1, bus.done2, bus.clear_done, 1'b0);
        checks++;
        if (chk_a !== chk_e) begin
            failures++;
            $display("FAIL cycle_model t=%0t got=%h expected=%h", $time, chk_a, chk_e);
        end
        if (chk_idle) begin
            if (bus.clear_req) begin
                for (int yy = 0; yy < 120; yy++)
                    for (int xx = 0; xx < 160; xx++)
                        exp_q.push_back(mk(1'b1, 1'b1, 8'(xx), 7'(yy), 3'b000, 1'b0, 1'b0, 1'b0, 1'b1));
                exp_q.push_back(mk(1'b1, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0));
            end else if (bus.req1 && (!bus.req2 || m_last == 2)) begin
                push_box(int'(bus.x1), int'(bus.y1), bus.col1, 3'b001);
                m_last = 1;
            end else if (bus.req2) begin
                push_box(int'(bus.x2), int'(bus.y2), bus.col2, 3'b010);
                m_last = 2;
            end
        end
    end

    // ---------------- driver / directed helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic run_expect(input vec_t v, input int budget, input string tag);
        int cyc = -1, plots = 0;
        logic [2:0] who = 3'b000, lcol = 3'b000;
        logic [7:0] fx = 8'd0, lx = 8'd0;
        logic [6:0] fy = 7'd0, ly = 7'd0;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (k == 1) begin
                fx = bus.vga_x;
                fy = bus.vga_y;
            end
            if (bus.vga_plot) begin
                plots++;
                lx   = bus.vga_x;
                ly   = bus.vga_y;
                lcol = bus.vga_colour;
            end
            if (bus.done1 || bus.done2 || bus.clear_done) begin
                cyc = k;
                who = {bus.clear_done, bus.done2, bus.done1};
                break;
            end
        end
        check({tag, "_done_cycle"}, cyc, v.cyc);
        check({tag, "_done_who"}, int'(who), int'(v.who));
        check({tag, "_plots"}, plots, v.plots);
        check({tag, "_first_x"}, int'(fx), int'(v.x));
        check({tag, "_first_y"}, int'(fy), int'(v.y));
        check({tag, "_last_x"}, int'(lx), int'(v.lx));
        check({tag, "_last_y"}, int'(ly), int'(v.ly));
        check({tag, "_colour"}, int'(lcol), (v.plots > 0) ? int'(v.col) : 0);
    endtask

    task automatic drive(input vec_t v);
        if (v.player == 1) begin
            bus.x1 = v.x; bus.y1 = v.y; bus.col1 = v.col; bus.req1 = 1'b1;
        end else begin
            bus.x2 = v.x; bus.y2 = v.y; bus.col2 = v.col; bus.req2 = 1'b1;
        end
    endtask

    vec_t rows[7];
    vec_t v_a, v_b, v_clr;

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rows[0] = '{1, 8'd10,  7'd20,  3'b100, 16, 17, 3'b001, 8'd13,  7'd23};
        rows[1] = '{2, 8'd158, 7'd118, 3'b011,  4, 17, 3'b010, 8'd159, 7'd119};
        rows[2] = '{1, 8'd159, 7'd0,   3'b010,  4, 17, 3'b001, 8'd159, 7'd3};
        rows[3] = '{2, 8'd0,   7'd119, 3'b110,  4, 17, 3'b010, 8'd3,   7'd119};
        rows[4] = '{1, 8'd200, 7'd50,  3'b111,  0, 17, 3'b001, 8'd0,   7'd0};
        rows[5] = '{2, 8'd156, 7'd116, 3'b101, 16, 17, 3'b010, 8'd159, 7'd119};
        rows[6] = '{1, 8'd255, 7'd127, 3'b001,  0, 17, 3'b001, 8'd0,   7'd0};

        bus.clear_req = 0; bus.req1 = 0; bus.req2 = 0;
        bus.x1 = 0; bus.y1 = 0; bus.col1 = 0; bus.x2 = 0; bus.y2 = 0; bus.col2 = 0;
        resetn = 1'b0;

        // reset held with a pending request
        drive(rows[0]);
        repeat (3) tick();
        check("reset_plot", int'(bus.vga_plot), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_dones", int'({bus.done1, bus.done2, bus.clear_done}), 0);
        check("reset_xyc", int'({bus.vga_x, bus.vga_y, bus.vga_colour}), 0);
        check("reset_state", int'(dbg_state), int'(S_IDLE));
        resetn = 1'b1;
        run_expect(rows[0], 40, "after_reset");
        bus.req1 = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            drive(rows[i]);
            run_expect(rows[i], 40, $sformatf("row%0d", i));
            bus.req1 = 1'b0;
            bus.req2 = 1'b0;
            tick();
        end

        // round robin from reset with both players asking continuously
        v_a = '{1, 8'd50, 7'd10, 3'b010, 16, 17, 3'b001, 8'd53, 7'd13};
        v_b = '{2, 8'd70, 7'd30, 3'b001, 16, 17, 3'b010, 8'd73, 7'd33};
        resetn = 1'b0;
        drive(v_a);
        drive(v_b);
        repeat (2) tick();
        resetn = 1'b1;
        for (int j = 0; j < 4; j++) begin
            run_expect((j % 2 == 0) ? v_a : v_b, 40, $sformatf("rr%0d", j));
            if (j == 3) begin
                bus.req1 = 1'b0;
                bus.req2 = 1'b0;
                tick();
            end else if (j % 2 == 0) begin
                bus.req1 = 1'b0;
                tick();
                bus.req1 = 1'b1;
            end else begin
                bus.req2 = 1'b0;
                tick();
                bus.req2 = 1'b1;
            end
        end

        // clear and player 1 rise together: clear first, then the box
        v_clr = '{0, 8'd0, 7'd0, 3'b000, 19200, 19201, 3'b100, 8'd159, 7'd119};
        v_a   = '{1, 8'd40, 7'd60, 3'b010, 16, 17, 3'b001, 8'd43, 7'd63};
        bus.clear_req = 1'b1;
        drive(v_a);
        run_expect(v_clr, 19300, "clear");
        bus.clear_req = 1'b0;
        tick();
        run_expect(v_a, 40, "after_clear");
        bus.req1 = 1'b0;
        tick();

        // reset during the sixth pixel abandons the box; it restarts from pixel 0
        v_a = '{1, 8'd30, 7'd40, 3'b101, 16, 17, 3'b001, 8'd33, 7'd43};
        drive(v_a);
        repeat (6) tick();
        check("mid_px6_x", int'(bus.vga_x), 31);
        check("mid_px6_y", int'(bus.vga_y), 41);
        #1 resetn = 1'b0;
        #1;
        check("mid_reset_plot", int'(bus.vga_plot), 0);
        check("mid_reset_busy", int'(bus.busy), 0);
        repeat (2) begin
            tick();
            check("mid_reset_no_done", int'(bus.done1), 0);
        end
        tick();
        resetn = 1'b1;
        run_expect(v_a, 40, "restart");
        bus.req1 = 1'b0;
        tick();

        // random player traffic, checked cycle by cycle against the model
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (bus.req1 && bus.done1) bus.req1 = 1'b0;
            else if (!bus.req1 && $urandom_range(0, 3) == 0) begin
                bus.x1 = 8'($urandom_range(0, 200));
                bus.y1 = 7'($urandom_range(0, 127));
                bus.col1 = 3'($urandom_range(0, 7));
                bus.req1 = 1'b1;
            end
            if (bus.req2 && bus.done2) bus.req2 = 1'b0;
            else if (!bus.req2 && $urandom_range(0, 3) == 0) begin
                bus.x2 = 8'($urandom_range(0, 200));
                bus.y2 = 7'($urandom_range(0, 127));
                bus.col2 = 3'($urandom_range(0, 7));
                bus.req2 = 1'b1;
            end
        end
        for (int c = 0; c < 100 && (bus.req1 || bus.req2); c++) begin
            tick();
            if (bus.req1 && bus.done1) bus.req1 = 1'b0;
            if (bus.req2 && bus.done2) bus.req2 = 1'b0;
        end
        check("random_drained", int'({bus.req1, bus.req2}), 0);
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
